// File: rtl/jtgng_vtimer.sv
// Parametrised video timing generator: H/Hsub/V counters, blanking, syncs and init strobes.
// Optional frame counter enabled by defining JTGNG_VTIMER_FRMCNT_EN.
module jtgng_vtimer #(
  parameter int W          = 9,
  parameter int HCNT_START = 128,
  parameter int HCNT_END   = 511,
  parameter int VCNT_START = 250,
  parameter int VCNT_END   = 511,
  parameter int HINIT_POS  = 134,
  parameter int HB_START   = 135,
  parameter int HB_END     = 263,
  parameter int OBJ_OFFSET = 3,
  parameter int HS_START   = 178,
  parameter int HS_END     = 206,
  parameter int VB_START   = 496,
  parameter int VB_END     = 272,
  parameter int VS_START   = 507,
  parameter int VS_END     = 510
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen12,
  input  logic         cen6,
  input  logic         flip,
  output logic [W-1:0] H,
  output logic         Hsub,
  output logic [W-1:0] V,
  output logic         Hinit,
  output logic         Vinit,
  output logic         LHBL,
  output logic         LHBL_obj,
  output logic         LVBL,
  output logic         HS,
  output logic         VS,
  output logic [7:0]   frame_cnt
);

  localparam int HLEN = HCNT_END + 1 - HCNT_START;

  // Object blanking leads the main blanking; positions falling before the line start wrap to its end.
  function automatic logic [W-1:0] obj_pos(input int hb);
    logic [W:0] raw;
    raw = (W+1)'(hb - OBJ_OFFSET);
    if (raw < (W+1)'(HCNT_START)) raw = raw + (W+1)'(HLEN);
    return raw[W-1:0];
  endfunction

  localparam logic [W-1:0] HSTART = W'(HCNT_START);
  localparam logic [W-1:0] HEND   = W'(HCNT_END);
  localparam logic [W-1:0] VSTART = W'(VCNT_START);
  localparam logic [W-1:0] VEND   = W'(VCNT_END);
  localparam logic [W-1:0] HINI   = W'(HINIT_POS);
  localparam logic [W-1:0] HBS    = W'(HB_START);
  localparam logic [W-1:0] HBE    = W'(HB_END);
  localparam logic [W-1:0] OBJ0   = obj_pos(HB_START);
  localparam logic [W-1:0] OBJ1   = obj_pos(HB_END);
  localparam logic [W-1:0] HSS    = W'(HS_START);
  localparam logic [W-1:0] HSE    = W'(HS_END);
  localparam logic [W-1:0] VBS    = W'(VB_START);
  localparam logic [W-1:0] VBE    = W'(VB_END);
  localparam logic [W-1:0] VSS    = W'(VS_START);
  localparam logic [W-1:0] VSE    = W'(VS_END);

  logic lhbl_p0, lhbl_p1, lhbl_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      H     <= HSTART;
      Hsub  <= 1'b0;
      Hinit <= 1'b0;
    end else if (cen12) begin
      Hsub  <= ~Hsub;
      Hinit <= (H == HINI);
      if (Hsub && H == HEND) H <= HSTART;
      else                   H <= H + W'(Hsub);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      V     <= VSTART;
      Vinit <= 1'b1;
    end else if (cen6 && H == HEND) begin
      Vinit <= (V == VEND);
      V     <= (V == VEND) ? VSTART : V + 1'b1;
    end
  end

  // Event stage p0; p1 is the extra delay used when the screen is flipped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lhbl_p0  <= 1'b0;
      lhbl_p1  <= 1'b0;
      lhbl_sel <= 1'b0;
      LHBL_obj <= 1'b0;
      LVBL     <= 1'b0;
      HS       <= 1'b0;
      VS       <= 1'b0;
    end else if (cen6) begin
      lhbl_p1 <= lhbl_p0;
      if (H == HBS)      lhbl_p0 <= 1'b0;
      else if (H == HBE) lhbl_p0 <= 1'b1;
      // flip is sampled only on blanking edges so a mid-line change cannot glitch LHBL
      if (H == HBS || H == HBE) lhbl_sel <= flip;
      if (H == OBJ0)      LHBL_obj <= 1'b0;
      else if (H == OBJ1) LHBL_obj <= 1'b1;
      if (H == HSS)      HS <= 1'b1;
      else if (H == HSE) HS <= 1'b0;
      if (H == HBS) begin
        if (V == VBS)      LVBL <= 1'b0;
        else if (V == VBE) LVBL <= 1'b1;
        if (V == VSS)      VS <= 1'b1;
        else if (V == VSE) VS <= 1'b0;
      end
    end
  end

  assign LHBL = lhbl_sel ? lhbl_p1 : lhbl_p0;

`ifdef JTGNG_VTIMER_FRMCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                frame_cnt <= 8'd0;
    else if (cen6 && H == HEND && V == VEND)   frame_cnt <= frame_cnt + 8'd1;
  end
`else
  assign frame_cnt = 8'd0;
`endif

  cen6_needs_cen12: assert property (@(posedge clk) disable iff (!rst_n) cen6 |-> cen12);

endmodule
